// File: rtl/uart_pkg.sv
// Shared serial-link definitions for the 9600 baud transmitter/receiver pair.
// Both ends use the same state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_W     = $clog2(DATA_BITS);
    localparam int BAUD_HZ   = 9600;

endpackage

// File: rtl/transmissor.sv
// UART transmitter: sends BYTES back-to-back 8N1 frames (byte 0 first, LSB first),
// one bit per rising edge of clk_9k6hz. The start bit is driven on the accepting edge.
module transmissor
    import uart_pkg::*;
#(
    parameter int BYTES     = 2,
    parameter int STOP_BITS = 1     // 1 or 2
) (
    input  logic                 clk_9k6hz,
    input  logic                 rst,
    input  logic                 send,
    input  logic [8*BYTES-1:0]   data,
    output logic                 tx,
    output logic                 busy,
    output logic                 concluded
);

    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;

    uart_state_t          state, state_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BCW-1:0]       byte_cnt;
    logic [8*BYTES-1:0]   buffer;
    logic                 tx_nxt, busy_nxt, concluded_nxt;
    logic                 bit_last, stop_done, last_byte;

    assign bit_last  = (bit_cnt == BIT_W'(DATA_BITS - 1));
    // In STOP, bit_cnt counts stop bits already driven; the edge after the last one
    // either launches the next start bit or finishes the word.
    assign stop_done = (bit_cnt == BIT_W'(STOP_BITS));
    assign last_byte = (byte_cnt == BCW'(BYTES - 1));

    always_ff @(posedge clk_9k6hz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            concluded <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            concluded <= concluded_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (send) state_nxt = DATA;
            DATA:    if (bit_last) state_nxt = STOP;
            STOP:    if (stop_done) state_nxt = last_byte ? IDLE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_nxt        = 1'b1;
        busy_nxt      = 1'b0;
        concluded_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    tx_nxt   = 1'b0;
                    busy_nxt = 1'b1;
                end
            end
            DATA: begin
                tx_nxt   = buffer[0];
                busy_nxt = 1'b1;
            end
            STOP: begin
                busy_nxt = 1'b1;
                if (stop_done) begin
                    if (last_byte) begin
                        busy_nxt      = 1'b0;
                        concluded_nxt = 1'b1;
                    end else begin
                        tx_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Buffer shifts right once per data bit, so consecutive bytes fall out in order.
    always_ff @(posedge clk_9k6hz or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (send) begin
                        buffer   <= data;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                DATA: begin
                    buffer  <= buffer >> 1;
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                end
                STOP: begin
                    if (!stop_done) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        bit_cnt <= '0;
                        if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmissor.sv
// Directed bench for transmissor: bit-exact stream checks, reset/ignore cases,
// a 2-stop-bit instance and a loopback into a small receiver model.
module tb_transmissor;

    logic        clk_9k6hz = 1'b0;
    logic        rst = 1'b1;
    logic        send = 1'b0, send2 = 1'b0;
    logic [15:0] data = '0, data2 = '0;
    logic        tx, busy, concluded;
    logic        tx2, busy2, concluded2;

    int checks = 0;
    int errors = 0;

    always #5 clk_9k6hz = ~clk_9k6hz;

    transmissor #(.BYTES(2), .STOP_BITS(1)) dut (
        .clk_9k6hz (clk_9k6hz),
        .rst       (rst),
        .send      (send),
        .data      (data),
        .tx        (tx),
        .busy      (busy),
        .concluded (concluded)
    );

    transmissor #(.BYTES(2), .STOP_BITS(2)) dut2 (
        .clk_9k6hz (clk_9k6hz),
        .rst       (rst),
        .send      (send2),
        .data      (data2),
        .tx        (tx2),
        .busy      (busy2),
        .concluded (concluded2)
    );

    // Receiver model on dut's line: samples once per clock, 8N1, two bytes per word.
    logic [3:0]  rx_pos;
    logic        rx_byte;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_lo;
    logic [15:0] rx_word = '0;
    int          rx_words = 0;
    int          conc_cnt = 0;

    always @(posedge clk_9k6hz) begin
        if (rst) begin
            rx_pos  <= '0;
            rx_byte <= 1'b0;
        end else if (rx_pos == 0) begin
            if (tx == 1'b0) rx_pos <= 4'd1;
        end else if (rx_pos <= 8) begin
            rx_sh  <= {tx, rx_sh[7:1]};
            rx_pos <= rx_pos + 4'd1;
        end else begin
            rx_pos <= '0;
            if (tx) begin
                if (rx_byte) begin
                    rx_word  <= {rx_sh, rx_lo};
                    rx_words <= rx_words + 1;
                    rx_byte  <= 1'b0;
                end else begin
                    rx_lo   <= rx_sh;
                    rx_byte <= 1'b1;
                end
            end
        end
        if (concluded) conc_cnt <= conc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_9k6hz);
        #1;
    endtask

    // Expected line level k bit-times after the accepting edge.
    function automatic logic exp_bit(input logic [15:0] d, input int k, input int sb);
        int len;
        int b;
        int p;
        len = 9 + sb;
        b = k / len;
        p = k % len;
        if (p == 0) return 1'b0;
        if (p <= 8) return d[8*b + p - 1];
        return 1'b1;
    endfunction

    // Sends one word on dut; optional stray request at bit-time glitch_at, optional reset at rst_at.
    task automatic word1(input string nm, input logic [15:0] d, input int glitch_at, input int rst_at);
        send = 1'b1;
        data = d;
        tick;
        send = 1'b0;
        chk({nm, "_start"}, tx, 1'b0);
        chk({nm, "_busy_rise"}, busy, 1'b1);
        for (int k = 1; k < 20; k++) begin
            if (k == glitch_at) begin
                send = 1'b1;
                data = 16'hFFFF;
            end
            tick;
            send = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_tx"}, tx, 1'b1);
                chk({nm, "_rst_busy"}, busy, 1'b0);
                chk({nm, "_rst_conc"}, concluded, 1'b0);
                tick;
                tick;
                rst = 1'b0;
                tick;
                chk({nm, "_rst_hold_tx"}, tx, 1'b1);
                chk({nm, "_rst_hold_conc"}, concluded, 1'b0);
                return;
            end
            chk($sformatf("%s_bit%0d", nm, k), tx, exp_bit(d, k, 1));
            chk($sformatf("%s_busy%0d", nm, k), busy, 1'b1);
            chk($sformatf("%s_conc%0d", nm, k), concluded, 1'b0);
        end
        tick;
        chk({nm, "_end_tx"}, tx, 1'b1);
        chk({nm, "_end_busy"}, busy, 1'b0);
        chk({nm, "_end_conc"}, concluded, 1'b1);
        tick;
        chk({nm, "_post_conc"}, concluded, 1'b0);
        chk({nm, "_post_tx"}, tx, 1'b1);
    endtask

    logic [19:0] a5c3_line;
    int          w0, c0;

    initial begin
        // Hand-derived line for 16'hA5C3, bit-time 0 in the LSB.
        a5c3_line = 20'b11_0100_1010_11_1000_0110;

        repeat (3) tick;
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_conc", concluded, 1'b0);
        rst = 1'b0;
        repeat (2) tick;
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Hand-computed A5C3 stream against the line table, with a stray request at E+5.
        send = 1'b1;
        data = 16'hA5C3;
        tick;
        send = 1'b0;
        chk("a5c3_b0", tx, a5c3_line[0]);
        for (int k = 1; k < 20; k++) begin
            if (k == 5) begin
                send = 1'b1;
                data = 16'hFFFF;
            end
            tick;
            send = 1'b0;
            chk($sformatf("a5c3_b%0d", k), tx, a5c3_line[k]);
            chk($sformatf("a5c3_busy%0d", k), busy, 1'b1);
        end
        tick;
        chk("a5c3_end_busy", busy, 1'b0);
        chk("a5c3_end_conc", concluded, 1'b1);
        tick;
        chk("a5c3_post_conc", concluded, 1'b0);
        chk("a5c3_stray_ignored_tx", tx, 1'b1);
        tick;

        word1("w0001", 16'h0001, 0, 0);
        tick;
        word1("w_rst", 16'h5AC3, 0, 12);
        word1("w1234", 16'h1234, 0, 0);
        word1("w_glitch", 16'h8421, 7, 0);

        // Two stop bits: 11-bit frames, completion at E+22.
        send2 = 1'b1;
        data2 = 16'h00FF;
        tick;
        send2 = 1'b0;
        chk("sb2_start", tx2, 1'b0);
        for (int k = 1; k < 22; k++) begin
            tick;
            chk($sformatf("sb2_bit%0d", k), tx2, exp_bit(16'h00FF, k, 2));
            chk($sformatf("sb2_busy%0d", k), busy2, 1'b1);
            chk($sformatf("sb2_conc%0d", k), concluded2, 1'b0);
        end
        tick;
        chk("sb2_end_busy", busy2, 1'b0);
        chk("sb2_end_conc", concluded2, 1'b1);
        chk("sb2_end_tx", tx2, 1'b1);
        tick;
        chk("sb2_post_conc", concluded2, 1'b0);

        // Loopback with send held high across the completion edge.
        tick;
        w0 = rx_words;
        c0 = conc_cnt;
        send = 1'b1;
        data = 16'hBEEF;
        tick;
        data = 16'h0F0F;
        repeat (19) tick;
        chk("lb_stop1", tx, 1'b1);
        tick;
        chk("lb_conc1", concluded, 1'b1);
        chk("lb_gap_tx", tx, 1'b1);
        chk("lb_rx_count1", rx_words, w0 + 1);
        chk("lb_rx_word1", rx_word, 16'hBEEF);
        tick;
        chk("lb_restart_tx", tx, 1'b0);
        chk("lb_restart_busy", busy, 1'b1);
        send = 1'b0;
        for (int i = 0; i < 40 && rx_words < w0 + 2; i++) tick;
        chk("lb_rx_count2", rx_words, w0 + 2);
        chk("lb_rx_word2", rx_word, 16'h0F0F);
        repeat (2) tick;
        chk("lb_conc_pulses", conc_cnt - c0, 2);
        chk("lb_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
